// File: rtl/data_mem_arbiter_if.sv
// Bundle of both requester handshakes and the data-memory control bus.
// slave = arbiter side; master = requesters plus memory side.
interface data_mem_arbiter_if;
  logic        r0_req;
  logic        r0_we;
  logic [10:0] r0_addr;
  logic [15:0] r0_wdata;
  logic        r0_ack;
  logic [15:0] r0_rdata;
  logic        r0_err;

  logic        r1_req;
  logic        r1_we;
  logic [10:0] r1_addr;
  logic [15:0] r1_wdata;
  logic        r1_ack;
  logic [15:0] r1_rdata;
  logic        r1_err;

  logic        mem_rd;
  logic        mem_wr;
  logic [10:0] mem_addr;
  logic [15:0] mem_in_data;
  logic [15:0] mem_out_data;
  logic        busy;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_out_data,
    output r0_ack, r0_rdata, r0_err,
    output r1_ack, r1_rdata, r1_err,
    output mem_rd, mem_wr, mem_addr, mem_in_data, busy
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_out_data,
    input  r0_ack, r0_rdata, r0_err,
    input  r1_ack, r1_rdata, r1_err,
    input  mem_rd, mem_wr, mem_addr, mem_in_data, busy
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter/sequencer for the BIP data memory (IDLE->ISSUE->RESP).
// Optional macro ADDR_CHECK_EN: out-of-range accesses are suppressed and flagged via ERR.
module data_mem_arbiter #(
  parameter int MEM_DEPTH     = 10,
  parameter int PRIORITY_MODE = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  data_mem_arbiter_if.slave  io_bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [1:0]  w_req;
  logic [1:0]  w_we;
  logic [10:0] w_addr  [2];
  logic [15:0] w_wdata [2];

  logic        w_accept;
  logic        w_win;
  logic        w_bad;

  logic        r_last_grant;
  logic        r_winner;
  logic        r_we;
  logic        r_bad;
  logic        r_busy;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic [10:0] r_mem_addr;
  logic [15:0] r_mem_in_data;

  assign w_req      = {io_bus.r1_req, io_bus.r0_req};
  assign w_we       = {io_bus.r1_we,  io_bus.r0_we};
  assign w_addr[0]  = io_bus.r0_addr;
  assign w_addr[1]  = io_bus.r1_addr;
  assign w_wdata[0] = io_bus.r0_wdata;
  assign w_wdata[1] = io_bus.r1_wdata;

`ifdef ADDR_CHECK_EN
  assign w_bad = (w_addr[w_win] >= 11'(MEM_DEPTH));
`else
  assign w_bad = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_win        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_accept     = 1'b1;
          w_state_next = S_ISSUE;
          // On a tie, round-robin hands the grant to whoever did not get the last one.
          if (&w_req)
            w_win = (PRIORITY_MODE == 1) ? 1'b0 : ~r_last_grant;
          else
            w_win = w_req[1];
        end
      end
      S_ISSUE: w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant  <= 1'b1;
      r_winner      <= 1'b0;
      r_we          <= 1'b0;
      r_bad         <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_in_data <= '0;
    end else if (w_accept) begin
      r_last_grant  <= w_win;
      r_winner      <= w_win;
      r_we          <= w_we[w_win];
      r_bad         <= w_bad;
      r_mem_rd      <= ~w_we[w_win] & ~w_bad;
      r_mem_wr      <=  w_we[w_win] & ~w_bad;
      r_mem_addr    <= w_addr[w_win];
      r_mem_in_data <= w_wdata[w_win];
    end else if (r_state == S_ISSUE) begin
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
    end
  end

  // Per-requester response registers; only the current winner's copy ever moves.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_req
      localparam logic ID = 1'(gi);
      logic        r_ack;
      logic        r_err;
      logic [15:0] r_rdata;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= '0;
        end else if (r_state == S_ISSUE && r_winner == ID) begin
          r_ack <= 1'b1;
          r_err <= r_bad;
          if (r_bad)
            r_rdata <= '0;
          else if (!r_we)
            r_rdata <= io_bus.mem_out_data;
        end else begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
        end
      end
    end
  endgenerate

  assign io_bus.r0_ack      = gen_req[0].r_ack;
  assign io_bus.r0_err      = gen_req[0].r_err;
  assign io_bus.r0_rdata    = gen_req[0].r_rdata;
  assign io_bus.r1_ack      = gen_req[1].r_ack;
  assign io_bus.r1_err      = gen_req[1].r_err;
  assign io_bus.r1_rdata    = gen_req[1].r_rdata;
  assign io_bus.mem_rd      = r_mem_rd;
  assign io_bus.mem_wr      = r_mem_wr;
  assign io_bus.mem_addr    = r_mem_addr;
  assign io_bus.mem_in_data = r_mem_in_data;
  assign io_bus.busy        = r_busy;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a round-robin instance with a memory model
// and a fixed-priority instance for the grant-order check.
module tb_data_mem_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  data_mem_arbiter_if bus ();
  data_mem_arbiter_if pbus ();

  data_mem_arbiter #(.MEM_DEPTH(10), .PRIORITY_MODE(0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus.slave)
  );
  data_mem_arbiter #(.MEM_DEPTH(10), .PRIORITY_MODE(1)) u_dut_prio (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(pbus.slave)
  );

  logic [15:0] mem [0:2047];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory acts at the negedge, like the real DataMemory.
  always @(negedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_in_data;
    if (bus.mem_rd) bus.mem_out_data <= mem[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h1000 + 16'(i);
    bus.mem_out_data  = 16'h0;
    pbus.mem_out_data = 16'h0;
    bus.r0_req = 0; bus.r0_we = 0; bus.r0_addr = 0; bus.r0_wdata = 0;
    bus.r1_req = 0; bus.r1_we = 0; bus.r1_addr = 0; bus.r1_wdata = 0;
    pbus.r0_req = 0; pbus.r0_we = 0; pbus.r0_addr = 0; pbus.r0_wdata = 0;
    pbus.r1_req = 0; pbus.r1_we = 0; pbus.r1_addr = 0; pbus.r1_wdata = 0;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_busy",   32'(bus.busy),   0);
    check("rst_mem_wr", 32'(bus.mem_wr), 0);
    check("rst_r0_ack", 32'(bus.r0_ack), 0);

    // R0 write 3 and R1 read 5 arrive together; R0 wins the first tie.
    rst_n = 1'b1;
    bus.r0_req = 1; bus.r0_we = 1; bus.r0_addr = 11'd3; bus.r0_wdata = 16'hA5A5;
    bus.r1_req = 1; bus.r1_we = 0; bus.r1_addr = 11'd5;
    tick();
    check("wr_mem_wr",   32'(bus.mem_wr),      1);
    check("wr_mem_rd",   32'(bus.mem_rd),      0);
    check("wr_mem_addr", 32'(bus.mem_addr),    3);
    check("wr_mem_din",  32'(bus.mem_in_data), 32'hA5A5);
    check("wr_busy",     32'(bus.busy),        1);
    check("wr_ack_early",32'(bus.r0_ack),      0);
    tick();
    check("wr_r0_ack",   32'(bus.r0_ack),      1);
    check("wr_r1_ack",   32'(bus.r1_ack),      0);
    check("wr_mem_wr_off",32'(bus.mem_wr),     0);
    check("wr_rdata_kept",32'(bus.r0_rdata),   0);
    tick();
    check("wr_ack_end",  32'(bus.r0_ack),      0);
    check("wr_idle",     32'(bus.busy),        0);
    bus.r0_we = 0; bus.r0_addr = 11'd3;
    tick();
    check("r1_first_rd", 32'(bus.mem_rd),      1);
    check("r1_addr",     32'(bus.mem_addr),    5);
    tick();
    check("r1_ack",      32'(bus.r1_ack),      1);
    check("r1_rdata",    32'(bus.r1_rdata),    32'h1005);
    check("r1_r0_quiet", 32'(bus.r0_ack),      0);
    tick();
    bus.r1_req = 0;
    tick();
    tick();
    check("rd_r0_ack",   32'(bus.r0_ack),      1);
    check("rd_r0_rdata", 32'(bus.r0_rdata),    32'hA5A5);
    tick();

    // Both reads held continuously: last grant was R0, so R1,R0,R1,R0.
    bus.r1_req = 1;
    for (int c = 0; c < 12; c++) begin
      logic e_any, e0, e1;
      tick();
      e_any = (c % 3 == 1);
      e0 = e_any && ((c / 3) % 2 == 1);
      e1 = e_any && ((c / 3) % 2 == 0);
      check($sformatf("rr_r0_ack_c%0d", c), 32'(bus.r0_ack), 32'(e0));
      check($sformatf("rr_r1_ack_c%0d", c), 32'(bus.r1_ack), 32'(e1));
      check($sformatf("rr_excl_c%0d", c), 32'(bus.r0_ack & bus.r1_ack), 0);
      if (e0) check("rr_r0_rdata", 32'(bus.r0_rdata), 32'hA5A5);
      if (e1) check("rr_r1_rdata", 32'(bus.r1_rdata), 32'h1005);
    end
    bus.r0_req = 0;
    bus.r1_req = 0;

    // R1 write to address 10, just past the valid range.
    bus.r1_req = 1; bus.r1_we = 1; bus.r1_addr = 11'd10; bus.r1_wdata = 16'hBEEF;
    tick();
`ifdef ADDR_CHECK_EN
    check("oob_mem_wr",  32'(bus.mem_wr),   0);
`else
    check("oob_mem_wr",  32'(bus.mem_wr),   1);
`endif
    check("oob_mem_addr",32'(bus.mem_addr), 10);
    tick();
    check("oob_r1_ack",  32'(bus.r1_ack),   1);
`ifdef ADDR_CHECK_EN
    check("oob_r1_err",  32'(bus.r1_err),   1);
    check("oob_r1_rdata",32'(bus.r1_rdata), 0);
`else
    check("oob_r1_err",  32'(bus.r1_err),   0);
`endif
    tick();
    bus.r1_req = 0;

    // Reset lands mid-ISSUE of an R1 write, between clock edges.
    bus.r1_req = 1; bus.r1_we = 1; bus.r1_addr = 11'd7; bus.r1_wdata = 16'h1234;
    tick();
    check("mid_mem_wr",  32'(bus.mem_wr),   1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_mem_wr",  32'(bus.mem_wr),   0);
    check("async_busy",    32'(bus.busy),     0);
    check("async_mem_addr",32'(bus.mem_addr), 0);
    check("async_r0_rdata",32'(bus.r0_rdata), 0);
    tick();
    check("rst_no_ack1",   32'(bus.r1_ack),   0);
    tick();
    check("rst_no_ack2",   32'(bus.r1_ack),   0);

    // After release, a tie goes to R0 again.
    rst_n = 1'b1;
    bus.r0_req = 1; bus.r0_we = 0; bus.r0_addr = 11'd3;
    bus.r1_req = 1; bus.r1_we = 0; bus.r1_addr = 11'd5;
    tick();
    check("rel_mem_rd",  32'(bus.mem_rd),   1);
    check("rel_mem_addr",32'(bus.mem_addr), 3);
    tick();
    check("rel_r0_ack",  32'(bus.r0_ack),   1);
    check("rel_r1_ack",  32'(bus.r1_ack),   0);
    check("rel_r0_rdata",32'(bus.r0_rdata), 32'hA5A5);
    tick();
    bus.r0_req = 0;
    bus.r1_req = 0;

    // Fixed priority: R0 wins every tie; R1 only once R0 lets go.
    pbus.r0_req = 1; pbus.r0_we = 0; pbus.r0_addr = 11'd1;
    pbus.r1_req = 1; pbus.r1_we = 0; pbus.r1_addr = 11'd2;
    for (int c = 0; c < 9; c++) begin
      tick();
      check($sformatf("pr_r0_ack_c%0d", c), 32'(pbus.r0_ack), 32'(c % 3 == 1));
      check($sformatf("pr_r1_ack_c%0d", c), 32'(pbus.r1_ack), 0);
    end
    pbus.r0_req = 0;
    tick();
    check("pr_r1_addr",  32'(pbus.mem_addr), 2);
    tick();
    check("pr_r1_ack",   32'(pbus.r1_ack),   1);
    check("pr_r0_quiet", 32'(pbus.r0_ack),   0);
    tick();
    pbus.r1_req = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
